// File: rtl/instr_loader_pkg.sv
// Shared types and default constants for the instruction loader and its memory.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int          DATA_W_DEFAULT   = 32;
  localparam int          DEPTH_DEFAULT    = 64;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: synchronous write, asynchronous read, contents never reset.
module instr_mem_array
  import instr_loader_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEFAULT,
  parameter  int DEPTH  = DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_loader.sv
// Handshaked instruction loader with LOAD/RUN gating and a bounded, NOP-masked fetch port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | after reset; nothing loaded, CPU held
//   ST_LOAD | accepting words at the auto-incrementing write pointer
//   ST_RUN  | program frozen, CPU runs, fetch returns loaded words
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter  int              DATA_W   = DATA_W_DEFAULT,
  parameter  int              DEPTH    = DEPTH_DEFAULT,
  parameter  logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
  localparam int              ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              LoadInstructions,
  input  logic [DATA_W-1:0] Instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       pc,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              overflow,
  output logic              cpu_run
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              overflow_q, overflow_d;
  logic              load_done_q, load_done_d;
  logic              cpu_run_q, cpu_run_d;

  logic              full;
  logic              entering;
  logic              wr_en;
  logic              drop;
  logic [ADDR_W-1:0] wr_addr;

  logic [ADDR_W-1:0] fetch_idx;
  logic              pc_in_range;
  logic              fetch_hit;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_pc_lsb;

  always_comb begin
    full        = (word_count_q == FULL_COUNT);
    entering    = LoadInstructions && (state_q != ST_LOAD);
    instr_ready = LoadInstructions && !full && !Reset;
    wr_en       = instr_valid && instr_ready;
    drop        = LoadInstructions && instr_valid && full;
    // The entry edge always restarts the program at word 0.
    wr_addr     = entering ? '0 : word_count_q[ADDR_W-1:0];

    state_d      = state_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      ST_IDLE: if (LoadInstructions)  state_d = ST_LOAD;
      ST_LOAD: if (!LoadInstructions) state_d = ST_RUN;
      ST_RUN:  if (LoadInstructions)  state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase

    if (entering) begin
      word_count_d = wr_en ? ONE_COUNT : '0;
      overflow_d   = 1'b0;
    end else begin
      if (wr_en) word_count_d = word_count_q + ONE_COUNT;
      if (drop)  overflow_d   = 1'b1;
    end

    load_done_d = (state_q == ST_LOAD) && !LoadInstructions;
    cpu_run_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      load_done_q  <= 1'b0;
      cpu_run_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      load_done_q  <= load_done_d;
      cpu_run_q    <= cpu_run_d;
    end
  end

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (Instruction),
    .raddr (fetch_idx),
    .rdata (mem_rdata)
  );

  // Byte address to word index; stale words past word_count are masked off.
  assign fetch_idx     = pc[ADDR_W+1:2];
  assign pc_in_range   = (pc[31:ADDR_W+2] == '0);
  assign fetch_hit     = (state_q == ST_RUN) && pc_in_range && ({1'b0, fetch_idx} < word_count_q);
  assign fetch_instr   = fetch_hit ? mem_rdata : NOP_WORD;
  assign unused_pc_lsb = ^pc[1:0];

  assign word_count = word_count_q;
  assign load_done  = load_done_q;
  assign overflow   = overflow_q;
  assign cpu_run    = cpu_run_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: a DEPTH=64 and a DEPTH=4 instance share stimulus and are checked against a program-list model.
module tb_instr_loader;

  localparam int unsigned DEP [2] = '{64, 4};
  localparam logic [31:0] NOPW [2] = '{32'h0000_0000, 32'h0000_0013};

  logic        clk = 1'b0;
  logic        Reset;
  logic        LoadInstructions;
  logic        instr_valid;
  logic [31:0] Instruction;
  logic [31:0] pc;

  logic        rdy_a, done_a, ovf_a, run_a;
  logic [31:0] fi_a;
  logic [6:0]  wc_a;
  logic        rdy_b, done_b, ovf_b, run_b;
  logic [31:0] fi_b;
  logic [2:0]  wc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_loader #(.DATA_W(32), .DEPTH(64), .NOP_WORD(32'h0000_0000)) dut_a (
    .clk(clk), .Reset(Reset), .LoadInstructions(LoadInstructions), .Instruction(Instruction),
    .instr_valid(instr_valid), .instr_ready(rdy_a), .pc(pc), .fetch_instr(fi_a),
    .word_count(wc_a), .load_done(done_a), .overflow(ovf_a), .cpu_run(run_a)
  );

  instr_loader #(.DATA_W(32), .DEPTH(4), .NOP_WORD(32'h0000_0013)) dut_b (
    .clk(clk), .Reset(Reset), .LoadInstructions(LoadInstructions), .Instruction(Instruction),
    .instr_valid(instr_valid), .instr_ready(rdy_b), .pc(pc), .fetch_instr(fi_b),
    .word_count(wc_b), .load_done(done_b), .overflow(ovf_b), .cpu_run(run_b)
  );

  // Model: mode 0=idle 1=load 2=run, the loaded program as a list with a length.
  int          m_mode [2] = '{0, 0};
  int          m_len  [2] = '{0, 0};
  logic        m_ovf  [2] = '{1'b0, 1'b0};
  logic        m_done [2] = '{1'b0, 1'b0};
  logic [31:0] m_prog [2][64];

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int d = 0; d < 2; d++) begin
        m_mode[d] = 0; m_len[d] = 0; m_ovf[d] = 1'b0; m_done[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic acc, drp;
        acc = LoadInstructions && instr_valid && (m_len[d] != int'(DEP[d]));
        drp = LoadInstructions && instr_valid && (m_len[d] == int'(DEP[d]));
        m_done[d] = (m_mode[d] == 1) && !LoadInstructions;
        if (LoadInstructions && m_mode[d] != 1) begin
          m_len[d] = 0;
          m_ovf[d] = 1'b0;
          if (acc) begin
            m_prog[d][0] = Instruction;
            m_len[d] = 1;
          end
          m_mode[d] = 1;
        end else if (m_mode[d] == 1) begin
          if (acc) begin
            m_prog[d][m_len[d]] = Instruction;
            m_len[d] = m_len[d] + 1;
          end
          if (drp) m_ovf[d] = 1'b1;
          if (!LoadInstructions) m_mode[d] = 2;
        end
      end
    end
  end

  function automatic logic [31:0] exp_fetch(int d, logic [31:0] a);
    if (m_mode[d] == 2 && a < DEP[d] * 4 && (a >> 2) < 32'(m_len[d]))
      return m_prog[d][a >> 2];
    return NOPW[d];
  endfunction

  function automatic logic exp_ready(int d);
    return !Reset && LoadInstructions && (m_len[d] != int'(DEP[d]));
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_ready",  64'(rdy_a),  64'(exp_ready(0)));
    chk("a_count",  64'(wc_a),   64'(m_len[0]));
    chk("a_done",   64'(done_a), 64'(m_done[0]));
    chk("a_ovf",    64'(ovf_a),  64'(m_ovf[0]));
    chk("a_run",    64'(run_a),  64'(m_mode[0] == 2));
    chk("a_fetch",  64'(fi_a),   64'(exp_fetch(0, pc)));
    chk("b_ready",  64'(rdy_b),  64'(exp_ready(1)));
    chk("b_count",  64'(wc_b),   64'(m_len[1]));
    chk("b_done",   64'(done_b), 64'(m_done[1]));
    chk("b_ovf",    64'(ovf_b),  64'(m_ovf[1]));
    chk("b_run",    64'(run_b),  64'(m_mode[1] == 2));
    chk("b_fetch",  64'(fi_b),   64'(exp_fetch(1, pc)));
  end

  function automatic logic [31:0] wd(int t, int i);
    if (t == 1 && i == 0) return 32'h2001_01A7;
    return (32'(t) << 28) | 32'(i * 3 + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(logic [31:0] w);
    LoadInstructions = 1'b1; instr_valid = 1'b1; Instruction = w;
    tick();
  endtask

  task automatic stall(int n);
    LoadInstructions = 1'b1; instr_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic go_run();
    LoadInstructions = 1'b0; instr_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    LoadInstructions = 1'b0; instr_valid = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();
  endtask

  // Drive pc and check the combinational fetch one step later (never lands on a clock edge).
  task automatic peek(string name, int d, logic [31:0] addr, logic [31:0] exp);
    pc = addr;
    #1;
    chk(name, 64'(d == 0 ? fi_a : fi_b), 64'(exp));
    #1;
  endtask

  initial begin
    Reset = 1'b1; LoadInstructions = 1'b0; instr_valid = 1'b0;
    Instruction = 32'h0; pc = 32'h0;
    tick();
    chk("rst_count", 64'(wc_a),  64'd0);
    chk("rst_run",   64'(run_a), 64'd0);
    chk("rst_ready", 64'(rdy_a), 64'd0);
    chk("rst_ovf",   64'(ovf_a), 64'd0);
    chk("rst_done",  64'(done_a), 64'd0);
    chk("rst_fetch", 64'(fi_a),  64'h0);
    Reset = 1'b0;
    tick();

    // Program load and run
    for (int i = 0; i < 11; i++) push(wd(1, i));
    chk("t1_count_load", 64'(wc_a), 64'd11);
    go_run();
    chk("t1_done",  64'(done_a), 64'd1);
    chk("t1_run",   64'(run_a),  64'd1);
    chk("t1_count", 64'(wc_a),   64'd11);
    peek("t1_pc0",   0, 32'd0,  32'h2001_01A7);
    peek("t1_pc40",  0, 32'd40, 32'h1000_001F);
    peek("t1_pc44",  0, 32'd44, 32'h0000_0000);
    peek("t1_pc2",   0, 32'd2,  32'h2001_01A7);
    peek("t6_pc256", 0, 32'd256, 32'h0000_0000);
    peek("t6_pcmax", 0, 32'hFFFF_FFFC, 32'h0000_0000);
    tick();
    chk("t1_done_once", 64'(done_a), 64'd0);

    // Backpressure
    push(wd(2, 0));
    push(wd(2, 1));
    peek("t6_load_pc0", 0, 32'd0, 32'h0000_0000);
    chk("t2_count2", 64'(wc_a), 64'd2);
    stall(3);
    chk("t2_hold", 64'(wc_a), 64'd2);
    for (int i = 2; i < 5; i++) push(wd(2, i));
    chk("t2_count5", 64'(wc_a), 64'd5);
    go_run();
    peek("t2_pc8", 0, 32'd8, 32'h2000_0007);

    // Overflow on the 4-deep instance
    do_reset();
    for (int i = 0; i < 4; i++) push(wd(3, i));
    chk("t3_ready_full", 64'(rdy_b), 64'd0);
    chk("t3_count_full", 64'(wc_b),  64'd4);
    chk("t3_ovf_before", 64'(ovf_b), 64'd0);
    push(wd(3, 4));
    chk("t3_ovf_set", 64'(ovf_b), 64'd1);
    push(wd(3, 5));
    chk("t3_ovf_sticky", 64'(ovf_b), 64'd1);
    chk("t3_count_held", 64'(wc_b),  64'd4);
    go_run();
    peek("t3_pc16", 1, 32'd16, 32'h0000_0013);
    peek("t3_pc12", 1, 32'd12, 32'h3000_000A);
    stall(1);
    chk("t3_ovf_clear", 64'(ovf_b), 64'd0);
    chk("t3_count_zero", 64'(wc_b), 64'd0);
    go_run();

    // Reload from RUN
    do_reset();
    for (int i = 0; i < 8; i++) push(wd(4, i));
    go_run();
    tick(); tick();
    for (int i = 0; i < 3; i++) push(wd(5, i));
    go_run();
    chk("t4_count", 64'(wc_a), 64'd3);
    peek("t4_pc0",  0, 32'd0,  32'h5000_0001);
    peek("t4_pc4",  0, 32'd4,  32'h5000_0004);
    peek("t4_pc8",  0, 32'd8,  32'h5000_0007);
    peek("t4_pc12", 0, 32'd12, 32'h0000_0000);

    // Asynchronous reset in the middle of a load
    do_reset();
    push(wd(6, 0));
    push(wd(6, 1));
    pc = 32'd0;
    #1;
    Reset = 1'b1;
    #1;
    chk("t5_count", 64'(wc_a),  64'd0);
    chk("t5_run",   64'(run_a), 64'd0);
    chk("t5_ready", 64'(rdy_a), 64'd0);
    chk("t5_ovf",   64'(ovf_a), 64'd0);
    chk("t5_fetch", 64'(fi_a),  64'h0);
    chk("t5_done",  64'(done_a), 64'd0);
    LoadInstructions = 1'b0; instr_valid = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("t5_no_done", 64'(done_a), 64'd0);
    chk("t5_idle",    64'(run_a),  64'd0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Parametrised instruction-memory front end for the single-cycle CPU. It replaces the ad-hoc "stream words while LoadInstructions is high" path with a handshaked loader: an auto-incrementing write pointer, a word count, and overflow detection. A LOAD/RUN state machine gates CPU execution, and the PC-indexed fetch port returns a NOP for any address outside the loaded program. It sits between the bench/host loader and the CPU fetch stage.

Parameters:
DATA_W, 32, instruction word width.
DEPTH, 64, instruction memory depth in words; must be a power of two, at least 2.
NOP_WORD, 32'h0000_0000, word returned for unloaded, out-of-range or non-RUN fetches.
ADDR_W, $clog2(DEPTH), localparam; word index width.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
Reset  in  1  asynchronous, active-high reset.
LoadInstructions  in  1  load-mode request level.
Instruction  in  DATA_W  word to load.
instr_valid  in  1  Instruction is valid this cycle.
instr_ready  out  1  loader accepts a word this cycle.
pc  in  32  CPU byte address for fetch.
fetch_instr  out  DATA_W  fetched instruction; combinational from pc and state.
word_count  out  ADDR_W+1  number of words loaded since the last LOAD entry.
load_done  out  1  one-cycle pulse on the LOAD->RUN transition.
overflow  out  1  sticky flag: a word was offered while memory was full.
cpu_run  out  1  high only in RUN; the CPU advances its PC only while this is high.

Behaviour:
- States: IDLE (after reset), LOAD, RUN.
- IDLE->LOAD and RUN->LOAD occur on an edge where LoadInstructions=1.
- LOAD->RUN occurs on an edge where LoadInstructions=0. load_done is high for exactly the following cycle.
- IDLE stays IDLE while LoadInstructions=0. RUN stays RUN while LoadInstructions=0.
- instr_ready = LoadInstructions & (word_count != DEPTH). It is forced to 0 while Reset is asserted.
- Write condition: LoadInstructions & instr_valid & instr_ready at the rising edge. Both IDLE and RUN edges count, so the first word is captured on the same edge that enters LOAD.
- Write address: 0 if state != LOAD (entry edge); otherwise word_count[ADDR_W-1:0].
- On the entry edge, word_count becomes 1 if a write occurs and 0 otherwise. On a LOAD write, word_count increments by 1.
- instr_valid=0 writes nothing and holds the pointer.
- Full (word_count == DEPTH): instr_ready=0. If instr_valid=1 with LoadInstructions=1, the word is dropped and overflow is set.
- overflow is cleared by Reset or on a LOAD entry edge. It is set on any drop, including a drop on the first LOAD cycle. Clear-on-entry has priority only on the entry edge itself.
- Fetch index = pc[ADDR_W+1:2]; pc[1:0] is ignored.
- fetch_instr = memory[index] only when all of the following hold: state==RUN, pc[31:ADDR_W+2]==0, index < word_count. Otherwise fetch_instr = NOP_WORD.
- Reset values: state IDLE, word_count 0, load_done 0, overflow 0, cpu_run 0, instr_ready 0, fetch_instr NOP_WORD.
- Memory contents are not reset; stale words are never visible because of the word_count bound.
- Reset mid-LOAD or mid-RUN: return to IDLE immediately (asynchronous) with all the values above. The partially loaded program is discarded logically.
- A reload from RUN discards the previous count; words from the old program beyond the new count read as NOP_WORD.
- No other latency: a written word is fetchable from the first RUN cycle.

Decomposition:
- Package instr_loader_pkg holds:
  - state enum (IDLE, LOAD, RUN);
  - default NOP_WORD constant;
  - default DEPTH constant.
- Sub-module instr_mem_array: DEPTH x DATA_W, synchronous write, asynchronous read, no reset.
- The FSM, pointer, count, flags and fetch masking stay in instr_loader.

Test Plan:
1. Load program (DEPTH=64). Reset, then LoadInstructions=1 with instr_valid=1 for 11 words (addi R1,R0,423 first), then LoadInstructions=0.
   Required: load_done high exactly 1 cycle, word_count=11, cpu_run=1, pc=0 -> 32'h200101A7, pc=40 -> word 10, pc=44 -> NOP_WORD, pc=2 -> 32'h200101A7.
2. Backpressure. During LOAD, deassert instr_valid for 3 cycles between words 2 and 3.
   Required: word_count holds at 2, then reaches 5 after 5 words; pc=8 in RUN returns the third word offered.
3. Overflow (DEPTH=4). Offer 6 valid words.
   Required: instr_ready=0 after the 4th, word_count=4, overflow=1, words 5-6 absent, pc=16 -> NOP_WORD. A new LOAD entry clears overflow.
4. Reload from RUN. Load 8 words, run, then load 3 new words.
   Required: word_count=3, pc=0..8 return the new words, pc=12 -> NOP_WORD despite stale contents.
5. Reset mid-load. Assert Reset after 2 words, asynchronously and mid-cycle.
   Required: immediately word_count=0, cpu_run=0, instr_ready=0, overflow=0, fetch_instr=NOP_WORD; no load_done pulse.
6. Fetch masking. During LOAD, pc=0 -> NOP_WORD. In RUN, pc=DEPTH*4 and pc=32'hFFFF_FFFC -> NOP_WORD.
